// File: rtl/write_back_pkg.sv
// write_back_pkg: shared encodings for the writeback stage (source select, load funct3, FSM states).
package write_back_pkg;
    localparam logic [1:0] WB_SRC_ALU = 2'b00;
    localparam logic [1:0] WB_SRC_MEM = 2'b01;
    localparam logic [1:0] WB_SRC_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        WB_RUN   = 1'b0,
        WB_LWAIT = 1'b1
    } wb_state_t;
endpackage

// File: rtl/write_back_load_align.sv
// load_align: selects and extends the addressed byte/halfword lane of a little-endian load word.
//   word   - raw 32-bit read data
//   offset - byte address bits [1:0]
//   funct3 - load width/sign code
//   value  - aligned, sign/zero-extended result (full word for LW and unknown codes)
module load_align
    import write_back_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        b = shifted[7:0];
        // halfword lane ignores offset[0], so a misaligned LH reads its containing halfword
        h = offset[1] ? word[31:16] : word[15:0];
        value = (funct3 == F3_LB)  ? {{24{b[7]}}, b}  :
                (funct3 == F3_LH)  ? {{16{h[15]}}, h} :
                (funct3 == F3_LBU) ? {24'd0, b}       :
                (funct3 == F3_LHU) ? {16'd0, h}       : word;
    end
endmodule

// File: rtl/write_back.sv
// write_back: final pipeline stage; picks the writeback source, waits on the data bus for loads.
//   Inputs : *_pype3 from the memory-access stage, ddata_in/dready_n/dbusy from the data bus.
//   Outputs: rf_we/rf_waddr/rf_wdata register-file write port (registered),
//            wb_keep upstream hold (combinational), load_err one-cycle timeout pulse,
//            retire_cnt retired-instruction count (present only when WB_RETIRE_CNT_EN is defined).
//   LOAD_TIMEOUT: maximum cycles spent in LWAIT before the load is abandoned (1..1023).
module write_back
    import write_back_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite_pype3,
    input  logic [1:0]  MemtoReg_pype3,
    input  logic [4:0]  WReg_pype3,
    input  logic [31:0] ALU_co_pype3,
    input  logic [31:0] PCp4_pype3,
    input  logic [31:0] Instraction_pype3,
    input  logic [31:0] ddata_in,
    input  logic        dready_n,
    input  logic        dbusy,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0] retire_cnt,
`endif
    output logic        wb_keep,
    output logic        load_err
);
    wb_state_t   state, state_n;
    logic [9:0]  cnt_q;
    logic [4:0]  rd_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        is_load, ready, lwait, keep, done, we_n, err_n;
    logic [4:0]  sel_rd;
    logic [1:0]  sel_off;
    logic [2:0]  sel_f3;
    logic [31:0] aligned, src;

    assign lwait   = (state == WB_LWAIT);
    assign is_load = RegWrite_pype3 && (MemtoReg_pype3 == WB_SRC_MEM);
    assign ready   = !dready_n && !dbusy;
    assign sel_rd  = lwait ? rd_q  : WReg_pype3;
    assign sel_off = lwait ? off_q : ALU_co_pype3[1:0];
    assign sel_f3  = lwait ? f3_q  : Instraction_pype3[14:12];
    // reset must release upstream immediately, not one edge later
    assign wb_keep = keep && !rst;

    load_align u_align (
        .word   (ddata_in),
        .offset (sel_off),
        .funct3 (sel_f3),
        .value  (aligned)
    );

    always_comb begin
        src = lwait                            ? aligned    :
              (MemtoReg_pype3 == WB_SRC_PC4)   ? PCp4_pype3 :
              (MemtoReg_pype3 == WB_SRC_MEM)   ? aligned    : ALU_co_pype3;
    end

    // The terminating LWAIT cycle (data or timeout) drops keep so upstream advances
    // on the same edge that retires the load; otherwise the load would be re-issued.
    always_comb begin
        state_n = state;
        keep    = 1'b0;
        done    = 1'b0;
        we_n    = 1'b0;
        err_n   = 1'b0;
        if (!lwait) begin
            if (is_load && !ready) begin
                state_n = WB_LWAIT;
                keep    = 1'b1;
            end else begin
                done = 1'b1;
                we_n = RegWrite_pype3 && (WReg_pype3 != 5'd0);
            end
        end else if (ready) begin
            state_n = WB_RUN;
            done    = 1'b1;
            we_n    = (rd_q != 5'd0);
        end else if (cnt_q == 10'(LOAD_TIMEOUT - 1)) begin
            state_n = WB_RUN;
            done    = 1'b1;
            err_n   = 1'b1;
        end else begin
            keep = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WB_RUN;
            cnt_q    <= '0;
            rd_q     <= '0;
            off_q    <= '0;
            f3_q     <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            load_err <= 1'b0;
        end else begin
            state    <= state_n;
            cnt_q    <= lwait ? cnt_q + 10'd1 : 10'd0;
            if (!lwait) begin
                rd_q  <= WReg_pype3;
                off_q <= ALU_co_pype3[1:0];
                f3_q  <= Instraction_pype3[14:12];
            end
            rf_we    <= we_n;
            rf_waddr <= sel_rd;
            rf_wdata <= src;
            load_err <= err_n;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            retire_cnt <= '0;
        else if (done && (Instraction_pype3 != 32'd0))
            retire_cnt <= retire_cnt + 64'd1;
    end
`else
    logic unused_instr;
    assign unused_instr = ^{Instraction_pype3[31:15], Instraction_pype3[11:0], done};
`endif
endmodule

// File: tb/tb_write_back.sv
// tb_write_back: directed table plus randomized loads/ALU ops against a transaction-level model.
module tb_write_back;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite_pype3;
    logic [1:0]  MemtoReg_pype3;
    logic [4:0]  WReg_pype3;
    logic [31:0] ALU_co_pype3, PCp4_pype3, Instraction_pype3, ddata_in;
    logic        dready_n, dbusy;
    logic        rf_we, wb_keep, load_err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
`endif
    longint unsigned exp_ret = 0;
    int tests = 0;
    int fails = 0;

    write_back #(.LOAD_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .RegWrite_pype3(RegWrite_pype3), .MemtoReg_pype3(MemtoReg_pype3),
        .WReg_pype3(WReg_pype3), .ALU_co_pype3(ALU_co_pype3),
        .PCp4_pype3(PCp4_pype3), .Instraction_pype3(Instraction_pype3),
        .ddata_in(ddata_in), .dready_n(dready_n), .dbusy(dbusy),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
`ifdef WB_RETIRE_CNT_EN
        .retire_cnt(retire_cnt),
`endif
        .wb_keep(wb_keep), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [1:0]  m2r;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic [31:0] data;
        int          delay;
        logic        exp_we;
        logic [31:0] exp_wd;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3);
        return {17'd0, f3, 12'h083};
    endfunction

    // Load result straight from the ISA rules: pick the lane arithmetically, then extend.
    function automatic logic [31:0] model_load(input logic [31:0] data, input int off, input int f3);
        int unsigned b, h;
        b = (data >> (8 * off)) & 32'hFF;
        h = (data >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            0: return (b < 128) ? b : b + 32'hFFFFFF00;
            1: return (h < 32768) ? h : h + 32'hFFFF0000;
            4: return b;
            5: return h;
            default: return data;
        endcase
    endfunction

    // Presents one instruction, holds it while keep is expected, then checks the write.
    // delay = number of not-ready cycles before data (loads only); > TO means timeout.
    task automatic run_instr(input vec_t v, input int id);
        int  waits;
        logic load;
        load  = v.rw && (v.m2r == 2'b01);
        waits = !load ? 0 : (v.delay > TO ? TO : v.delay);
        RegWrite_pype3 = v.rw; MemtoReg_pype3 = v.m2r; WReg_pype3 = v.rd;
        ALU_co_pype3 = v.alu; PCp4_pype3 = v.pc4; Instraction_pype3 = v.instr;
        for (int k = 0; k < waits; k++) begin
            dready_n = 1'($urandom_range(0, 1));
            dbusy    = dready_n ? 1'($urandom_range(0, 1)) : 1'b1;
            ddata_in = $urandom;
            #1 chk($sformatf("keep_hi[%0d.%0d]", id, k), wb_keep, 1);
            @(posedge clk); #1;
            chk($sformatf("we_wait[%0d.%0d]", id, k), rf_we, 0);
            chk($sformatf("err_wait[%0d.%0d]", id, k), load_err, 0);
        end
        if (load && v.delay > TO) begin
            dready_n = 1'b1; dbusy = 1'($urandom_range(0, 1)); ddata_in = $urandom;
        end else if (load) begin
            dready_n = 1'b0; dbusy = 1'b0; ddata_in = v.data;
        end else begin
            dready_n = 1'($urandom_range(0, 1)); dbusy = 1'($urandom_range(0, 1)); ddata_in = $urandom;
        end
        #1 chk($sformatf("keep_lo[%0d]", id), wb_keep, 0);
        @(posedge clk); #1;
        if (v.instr != 32'd0) exp_ret++;
        chk($sformatf("we[%0d]", id), rf_we, v.exp_we);
        if (v.exp_we) begin
            chk($sformatf("waddr[%0d]", id), rf_waddr, v.rd);
            chk($sformatf("wdata[%0d]", id), rf_wdata, v.exp_wd);
        end
        chk($sformatf("err[%0d]", id), load_err, v.exp_err);
`ifdef WB_RETIRE_CNT_EN
        chk($sformatf("retire[%0d]", id), retire_cnt, exp_ret);
`endif
    endtask

    initial begin
        vec_t tbl[16];
        vec_t r;
        int   f3;
        tbl[0]  = '{1, 2'b00, 5'd5,  32'h1234,     32'h0,   32'h00000033, 32'h0,        0, 1, 32'h00001234, 0};
        tbl[1]  = '{1, 2'b10, 5'd1,  32'h9,        32'h104, 32'h0000006F, 32'h0,        0, 1, 32'h00000104, 0};
        tbl[2]  = '{1, 2'b10, 5'd0,  32'h9,        32'h108, 32'h0000006F, 32'h0,        0, 0, 32'h0,        0};
        tbl[3]  = '{1, 2'b01, 5'd7,  32'h1003,     32'h0,   mk(3'd0),     32'h80FF0011, 3, 1, 32'hFFFFFF80, 0};
        tbl[4]  = '{1, 2'b01, 5'd8,  32'h2002,     32'h0,   mk(3'd5),     32'hBEEF1234, 0, 1, 32'h0000BEEF, 0};
        tbl[5]  = '{1, 2'b01, 5'd9,  32'h10,       32'h0,   mk(3'd2),     32'h0,        9, 0, 32'h0,        1};
        tbl[6]  = '{1, 2'b00, 5'd10, 32'hCAFE,     32'h0,   32'h00000033, 32'h0,        0, 1, 32'h0000CAFE, 0};
        tbl[7]  = '{1, 2'b01, 5'd11, 32'h20,       32'h0,   mk(3'd2),     32'h12345678, 4, 1, 32'h12345678, 0};
        tbl[8]  = '{1, 2'b01, 5'd12, 32'h21,       32'h0,   mk(3'd2),     32'hA1B2C3D4, 1, 1, 32'hA1B2C3D4, 0};
        tbl[9]  = '{1, 2'b01, 5'd13, 32'h23,       32'h0,   mk(3'd1),     32'h80017FFF, 0, 1, 32'hFFFF8001, 0};
        tbl[10] = '{1, 2'b01, 5'd0,  32'h24,       32'h0,   mk(3'd0),     32'h000000FF, 2, 0, 32'h0,        0};
        tbl[11] = '{1, 2'b11, 5'd14, 32'h55AA,     32'h77,  32'h00000033, 32'h0,        0, 1, 32'h000055AA, 0};
        tbl[12] = '{1, 2'b01, 5'd15, 32'h25,       32'h0,   mk(3'd3),     32'h0F0F0F0F, 2, 1, 32'h0F0F0F0F, 0};
        tbl[13] = '{0, 2'b00, 5'd0,  32'h0,        32'h0,   32'h0,        32'h0,        0, 0, 32'h0,        0};
        tbl[14] = '{0, 2'b00, 5'd16, 32'h40,       32'h0,   32'h00002023, 32'h0,        0, 0, 32'h0,        0};
        tbl[15] = '{1, 2'b01, 5'd17, 32'h31,       32'h0,   mk(3'd4),     32'h00009900, 1, 1, 32'h00000099, 0};

        rst = 1'b1;
        RegWrite_pype3 = 0; MemtoReg_pype3 = 0; WReg_pype3 = 0; ALU_co_pype3 = 0;
        PCp4_pype3 = 0; Instraction_pype3 = 0; ddata_in = 0; dready_n = 1; dbusy = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_err", load_err, 0);
        chk("rst_keep", wb_keep, 0);
`ifdef WB_RETIRE_CNT_EN
        chk("rst_retire", retire_cnt, 0);
`endif

        for (int i = 0; i < 16; i++) run_instr(tbl[i], i);

        // reset while a load is stalled in LWAIT
        RegWrite_pype3 = 1; MemtoReg_pype3 = 2'b01; WReg_pype3 = 5'd3;
        ALU_co_pype3 = 32'h8; Instraction_pype3 = mk(3'd2); dready_n = 1; dbusy = 0;
        @(posedge clk); #1;
        chk("lw_keep", wb_keep, 1);
        rst = 1'b1;
        #1 chk("rstlw_keep_now", wb_keep, 0);
        @(posedge clk); #1;
        RegWrite_pype3 = 0; MemtoReg_pype3 = 0; WReg_pype3 = 0; ALU_co_pype3 = 0; Instraction_pype3 = 0;
        rst = 1'b0;
        exp_ret = 0;
        chk("rstlw_we", rf_we, 0);
        chk("rstlw_err", load_err, 0);
        #1 chk("rstlw_keep", wb_keep, 0);
`ifdef WB_RETIRE_CNT_EN
        chk("rstlw_retire", retire_cnt, 0);
`endif
        @(posedge clk); #1;
        chk("rstlw_we2", rf_we, 0);
        chk("rstlw_err2", load_err, 0);

        for (int i = 0; i < 300; i++) begin
            r.rw    = 1'($urandom_range(0, 1));
            r.m2r   = 2'($urandom_range(0, 3));
            r.rd    = 5'($urandom_range(0, 31));
            r.alu   = $urandom;
            r.pc4   = $urandom;
            r.data  = $urandom;
            f3      = $urandom_range(0, 7);
            r.instr = ($urandom_range(0, 15) == 0) ? 32'd0 : (($urandom & 32'hFFFF8FFF) | (f3 << 12) | 32'h3);
            r.delay = $urandom_range(0, TO + 2);
            f3      = (r.instr >> 12) & 7;
            r.exp_err = 0;
            if (r.rw && r.m2r == 2'b01) begin
                r.exp_err = (r.delay > TO);
                r.exp_we  = !r.exp_err && (r.rd != 0);
                r.exp_wd  = model_load(r.data, r.alu % 4, f3);
            end else begin
                r.exp_we = r.rw && (r.rd != 0);
                r.exp_wd = (r.m2r == 2'b10) ? r.pc4 : (r.m2r == 2'b01 ? 32'h0 : r.alu);
                if (r.m2r == 2'b01) r.exp_we = 0;
            end
            run_instr(r, 100 + i);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
